conn_setup_issuer: RTL and testbench

Host-side initiator for the NIC connection-setup command interface. It accepts one high-level open/close request and emits the ordered ConnSetupFrame command sequence that the RPC unit's setup parser consumes. It then waits for ConnSetupStatus from the connection manager and returns a single completion (ok/error/timeout). It sits between the CPU control path and the rpc block's conn_setup_en_in/conn_setup_frame_in pins.

---
 rtl/conn_setup_issuer_pkg.sv | 53 +++++
 rtl/conn_setup_issuer_timer.sv | 30 +++
 rtl/conn_setup_issuer.sv | 222 ++++++++++++++++++++++
 tb/tb_conn_setup_issuer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conn_setup_issuer_pkg.sv
// NIC connection-setup definitions shared between the host-side issuer and
// the rpc block's setup parser. Frame, command and status layouts match the
// rpc block; ConnSetupReq and the completion codes belong to the issuer.
package nic_defs;

   // Setup-parser command codes; 0 is the idle/no-command value.
   typedef enum logic [2:0] {
      setUpNone         = 3'd0,
      setUpConnId       = 3'd1,
      setUpOpen         = 3'd2,
      setUpDestIPv4     = 3'd3,
      setUpDestPort     = 3'd4,
      setUpClientFlowId = 3'd5,
      setUpEnable       = 3'd6
   } ConnSetupCmd;

   typedef struct packed {
      ConnSetupCmd cmd;
      logic [31:0] data;
   } ConnSetupFrame;

   typedef struct packed {
      logic valid;
      logic error;
   } ConnSetupStatus;

   typedef struct packed {
      logic [31:0] conn_id;
      logic        open;
      logic [31:0] dest_ip;
      logic [15:0] dest_port;
      logic [15:0] client_flow_id;
   } ConnSetupReq;

   typedef enum logic [1:0] {
      CSI_OK      = 2'd0,
      CSI_NIC_ERR = 2'd1,
      CSI_TIMEOUT = 2'd2
   } done_status_t;

   // Shared wait timer width; gap waits are clamped to an 8-bit range.
   localparam int CSI_TMR_W   = 32;
   localparam int CSI_GAP_MAX = 255;

   function automatic ConnSetupFrame mk_frame(input ConnSetupCmd cmd,
                                              input logic [31:0] data);
      ConnSetupFrame f;
      f.cmd  = cmd;
      f.data = data;
      return f;
   endfunction

endpackage

// File: rtl/conn_setup_issuer_timer.sv
// Load/count/expire down-counter. Used for inter-frame gaps and for the
// status timeout; expired is high whenever the count sits at zero.
module conn_setup_timer
   import nic_defs::*;
#(
   parameter int W = CSI_TMR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] cnt;

   // Load has priority; counting stops at zero.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/conn_setup_issuer.sv
// Host-side connection-setup initiator. Turns one open/close request into
// the ordered ConnSetupFrame sequence, waits for ConnSetupStatus and emits a
// single completion (OK / NIC_ERROR / TIMEOUT).
// Optional: define CONN_SETUP_RETRY_EN to resend the whole sequence after a
// timeout, up to MAX_RETRIES extra attempts.
module conn_setup_issuer
   import nic_defs::*;
#(
   parameter int NIC_ID         = 0,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int FRAME_GAP      = 0,
   parameter int MAX_RETRIES    = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req_valid,
   output logic           req_ready,
   input  ConnSetupReq    req_in,
   output logic           conn_setup_en_out,
   output ConnSetupFrame  conn_setup_frame_out,
   input  ConnSetupStatus conn_setup_status_in,
   output logic           done_valid,
   output logic [31:0]    done_conn_id,
   output logic [1:0]     done_status,
   output logic           busy
);

   // A zero-cycle timeout cannot be expressed by the wait state.
   if (TIMEOUT_CYCLES < 1 || MAX_RETRIES < 0 || FRAME_GAP < 0) begin : g_cfg_err
      $error("conn_setup_issuer[%0d]: bad parameters (TIMEOUT_CYCLES >= 1 required)", NIC_ID);
   end

   localparam int GAP_SAT = (FRAME_GAP > CSI_GAP_MAX) ? CSI_GAP_MAX : FRAME_GAP;
   // Timer is loaded with N-1 so it spends exactly N cycles before expiring.
   localparam logic [CSI_TMR_W-1:0] GAP_LOAD = CSI_TMR_W'(GAP_SAT - 1);
   localparam logic [CSI_TMR_W-1:0] TO_LOAD  = CSI_TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CONN_ID, S_OPEN, S_DEST_IP, S_DEST_PORT, S_FLOW_ID,
      S_ENABLE, S_GAP, S_WAIT_STATUS, S_RESP
   } state_t;

   state_t         state, state_d, gap_ret, gap_ret_d, frame_nxt;
   ConnSetupReq    req_q;
   ConnSetupFrame  frame_q, frame_d;
   logic           en_q, en_d;
   logic           done_q, done_d;
   logic [31:0]    done_id_q;
   done_status_t   done_st_q, done_st_d;
   logic           accept;
   logic           tmr_load, tmr_en, tmr_expired;
   logic [CSI_TMR_W-1:0] tmr_val;
`ifdef CONN_SETUP_RETRY_EN
   localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRIES);
   logic [7:0] retry_cnt;
   logic       retry_inc;
`endif

   conn_setup_timer #(.W(CSI_TMR_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .expired  (tmr_expired)
   );

   assign tmr_en = (state == S_GAP) || (state == S_WAIT_STATUS);

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_d;
   end

   // Next state, frame contents, timer loads and completion decode.
   always_comb begin
      state_d   = state;
      gap_ret_d = gap_ret;
      frame_nxt = S_IDLE;
      en_d      = 1'b0;
      frame_d   = '0;
      done_d    = 1'b0;
      done_st_d = CSI_OK;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      accept    = 1'b0;
`ifdef CONN_SETUP_RETRY_EN
      retry_inc = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               accept  = 1'b1;
               state_d = S_CONN_ID;
            end
         end
         S_CONN_ID: begin
            en_d      = 1'b1;
            frame_d   = mk_frame(setUpConnId, req_q.conn_id);
            frame_nxt = S_OPEN;
         end
         S_OPEN: begin
            en_d      = 1'b1;
            frame_d   = mk_frame(setUpOpen, {31'd0, req_q.open});
            // A close only needs the id and the enable.
            frame_nxt = req_q.open ? S_DEST_IP : S_ENABLE;
         end
         S_DEST_IP: begin
            en_d      = 1'b1;
            frame_d   = mk_frame(setUpDestIPv4, req_q.dest_ip);
            frame_nxt = S_DEST_PORT;
         end
         S_DEST_PORT: begin
            en_d      = 1'b1;
            frame_d   = mk_frame(setUpDestPort, {16'd0, req_q.dest_port});
            frame_nxt = S_FLOW_ID;
         end
         S_FLOW_ID: begin
            en_d      = 1'b1;
            frame_d   = mk_frame(setUpClientFlowId, {16'd0, req_q.client_flow_id});
            frame_nxt = S_ENABLE;
         end
         S_ENABLE: begin
            en_d      = 1'b1;
            frame_d   = mk_frame(setUpEnable, 32'd0);
            frame_nxt = S_WAIT_STATUS;
         end
         S_GAP: begin
            if (tmr_expired)
               state_d = gap_ret;
         end
         S_WAIT_STATUS: begin
            // Status is checked first so it wins over a same-cycle expiry.
            if (conn_setup_status_in.valid) begin
               state_d   = S_RESP;
               done_d    = 1'b1;
               done_st_d = conn_setup_status_in.error ? CSI_NIC_ERR : CSI_OK;
            end else if (tmr_expired) begin
`ifdef CONN_SETUP_RETRY_EN
               if (retry_cnt < RETRY_LIM) begin
                  retry_inc = 1'b1;
                  state_d   = S_CONN_ID;
               end else begin
                  state_d   = S_RESP;
                  done_d    = 1'b1;
                  done_st_d = CSI_TIMEOUT;
               end
`else
               state_d   = S_RESP;
               done_d    = 1'b1;
               done_st_d = CSI_TIMEOUT;
`endif
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Every frame state leaves after one cycle: straight on, via the gap
      // state, or into the status wait (no gap after the enable frame).
      if (en_d) begin
         if (frame_nxt == S_WAIT_STATUS) begin
            state_d  = S_WAIT_STATUS;
            tmr_load = 1'b1;
            tmr_val  = TO_LOAD;
         end else if (GAP_SAT > 0) begin
            state_d   = S_GAP;
            gap_ret_d = frame_nxt;
            tmr_load  = 1'b1;
            tmr_val   = GAP_LOAD;
         end else begin
            state_d = frame_nxt;
         end
      end
   end

   // Request latch, registered frame/done outputs and gap return state.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_q     <= '0;
         gap_ret   <= S_IDLE;
         frame_q   <= '0;
         en_q      <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         done_st_q <= CSI_OK;
      end else begin
         if (accept)
            req_q <= req_in;
         gap_ret <= gap_ret_d;
         frame_q <= frame_d;
         en_q    <= en_d;
         done_q  <= done_d;
         if (done_d) begin
            done_id_q <= req_q.conn_id;
            done_st_q <= done_st_d;
         end
      end
   end

`ifdef CONN_SETUP_RETRY_EN
   // Attempt counter, restarted with every accepted request.
   always_ff @(posedge clk) begin
      if (reset || accept)
         retry_cnt <= '0;
      else if (retry_inc)
         retry_cnt <= retry_cnt + 1'b1;
   end
`endif

   assign req_ready            = (state == S_IDLE);
   assign busy                 = (state != S_IDLE);
   assign conn_setup_en_out    = en_q;
   assign conn_setup_frame_out = frame_q;
   assign done_valid           = done_q;
   assign done_conn_id         = done_id_q;
   assign done_status          = done_st_q;

endmodule

// File: tb/tb_conn_setup_issuer.sv
// Bench for conn_setup_issuer: two instances (FRAME_GAP 0 and 2) share the
// request input; each has its own status responder. Expected frame lists,
// spacing, completion code and completion time come from a request-level
// model of the protocol.
module tb_conn_setup_issuer;
   import nic_defs::*;

   localparam int NI = 2;
   localparam int TO = 16;
   localparam int MR = 2;
`ifdef CONN_SETUP_RETRY_EN
   localparam int ATTEMPTS = MR + 1;
`else
   localparam int ATTEMPTS = 1;
`endif

   typedef ConnSetupFrame frame_q_t[$];

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           req_valid = 1'b0;
   ConnSetupReq    req_in = '0;
   logic           req_ready [NI];
   logic           cs_en [NI];
   ConnSetupFrame  cs_frame [NI];
   ConnSetupStatus cs_st [NI];
   logic           done_valid [NI];
   logic [31:0]    done_id [NI];
   logic [1:0]     done_st [NI];
   logic           busy [NI];

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // monitor / responder state
   ConnSetupFrame fq [NI][$];
   int            fc [NI][$];
   int            dq_cyc [NI][$];
   logic [31:0]   dq_id [NI][$];
   logic [1:0]    dq_st [NI][$];
   logic          rdy_after [NI];
   logic          dn_prev [NI];
   int            acc_cyc [NI];
   int            rs_cnt [NI];
   int            rs_kind = 2;
   int            rs_dly = 1;
   logic          stray = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      conn_setup_issuer #(
         .NIC_ID(g), .TIMEOUT_CYCLES(TO), .FRAME_GAP(2 * g), .MAX_RETRIES(MR)
      ) u_dut (
         .clk                  (clk),
         .reset                (reset),
         .req_valid            (req_valid),
         .req_ready            (req_ready[g]),
         .req_in               (req_in),
         .conn_setup_en_out    (cs_en[g]),
         .conn_setup_frame_out (cs_frame[g]),
         .conn_setup_status_in (cs_st[g]),
         .done_valid           (done_valid[g]),
         .done_conn_id         (done_id[g]),
         .done_status          (done_st[g]),
         .busy                 (busy[g])
      );
   end

   // Capture frames/completions and play the connection manager.
   always @(negedge clk) begin : mon
      logic vld;
      for (int i = 0; i < NI; i++) begin
         if (cs_en[i] === 1'b1) begin
            fq[i].push_back(cs_frame[i]);
            fc[i].push_back(cyc);
         end
         if (done_valid[i] === 1'b1) begin
            dq_cyc[i].push_back(cyc);
            dq_id[i].push_back(done_id[i]);
            dq_st[i].push_back(done_st[i]);
         end
         if (dn_prev[i]) rdy_after[i] = req_ready[i];
         dn_prev[i] = (done_valid[i] === 1'b1);
         if (req_valid && req_ready[i] === 1'b1) acc_cyc[i] = cyc;
         vld = 1'b0;
         if (cs_en[i] === 1'b1 && cs_frame[i].cmd == setUpEnable) begin
            if (rs_kind != 2) rs_cnt[i] = rs_dly;
         end else if (rs_cnt[i] > 0) begin
            rs_cnt[i]--;
            vld = (rs_cnt[i] == 0);
         end
         cs_st[i].valid = vld | stray;
         cs_st[i].error = (vld && rs_kind == 1) | stray;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Frame list a request must produce, straight from the command order.
   function automatic frame_q_t model_frames(input ConnSetupReq r);
      frame_q_t q;
      q.push_back('{cmd: setUpConnId, data: r.conn_id});
      q.push_back('{cmd: setUpOpen, data: {31'd0, r.open}});
      if (r.open) begin
         q.push_back('{cmd: setUpDestIPv4, data: r.dest_ip});
         q.push_back('{cmd: setUpDestPort, data: {16'd0, r.dest_port}});
         q.push_back('{cmd: setUpClientFlowId, data: {16'd0, r.client_flow_id}});
      end
      q.push_back('{cmd: setUpEnable, data: 32'd0});
      return q;
   endfunction

   task automatic clear_mon();
      for (int i = 0; i < NI; i++) begin
         fq[i].delete(); fc[i].delete();
         dq_cyc[i].delete(); dq_id[i].delete(); dq_st[i].delete();
         rdy_after[i] = 1'b0;
         acc_cyc[i] = -100;
      end
   endtask

   task automatic check_outputs_reset(input string tag);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("%s[%0d] en", tag, i), cs_en[i], 0);
         check($sformatf("%s[%0d] frame", tag, i), cs_frame[i], 0);
         check($sformatf("%s[%0d] done", tag, i), done_valid[i], 0);
         check($sformatf("%s[%0d] done_id", tag, i), done_id[i], 0);
         check($sformatf("%s[%0d] done_st", tag, i), done_st[i], 0);
         check($sformatf("%s[%0d] ready", tag, i), req_ready[i], 1);
         check($sformatf("%s[%0d] busy", tag, i), busy[i], 0);
      end
   endtask

   // kind: 0 = status OK, 1 = status error, 2 = no status; dly cycles after ENABLE frame
   task automatic run_txn(input string tag, input ConnSetupReq r, input int kind, input int dly);
      frame_q_t one;
      int n, att, exp_st, exp_off, last;
      logic st_in_time;
      one = model_frames(r);
      n = one.size();
      st_in_time = (kind != 2) && (dly <= TO - 1);
      att = st_in_time ? 1 : ATTEMPTS;
      exp_st = st_in_time ? kind : 2;
      exp_off = st_in_time ? dly + 1 : TO;
      clear_mon();
      rs_kind = kind;
      rs_dly = dly;
      @(posedge clk); #1;
      req_in = r;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if (dq_cyc[0].size() != 0 && dq_cyc[1].size() != 0) break;
         @(posedge clk);
      end
      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("%s[%0d] nframes", tag, i), fq[i].size(), n * att);
         for (int j = 0; j < fq[i].size() && j < n * att; j++) begin
            check($sformatf("%s[%0d] frame%0d", tag, i, j), fq[i][j], one[j % n]);
            if (j % n != 0)
               check($sformatf("%s[%0d] spacing%0d", tag, i, j),
                     fc[i][j] - fc[i][j - (j % n)], (j % n) * (2 * i + 1));
         end
         if (fc[i].size() != 0)
            check($sformatf("%s[%0d] first_lat", tag, i), fc[i][0] - acc_cyc[i], 2);
         check($sformatf("%s[%0d] ndone", tag, i), dq_cyc[i].size(), 1);
         if (dq_cyc[i].size() != 0 && fc[i].size() != 0) begin
            last = fc[i][fc[i].size() - 1];
            check($sformatf("%s[%0d] done_time", tag, i), dq_cyc[i][0] - last, exp_off);
            check($sformatf("%s[%0d] done_id", tag, i), dq_id[i][0], r.conn_id);
            check($sformatf("%s[%0d] done_st", tag, i), dq_st[i][0], exp_st);
         end
         check($sformatf("%s[%0d] ready_after", tag, i), rdy_after[i], 1);
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin : main
      ConnSetupReq r;
      for (int i = 0; i < NI; i++) begin
         rs_cnt[i] = 0;
         dn_prev[i] = 1'b0;
      end
      clear_mon();

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_reset("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // stray status while idle is ignored
      clear_mon();
      stray = 1'b1;
      @(posedge clk); #1;
      stray = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("stray[%0d] ndone", i), dq_cyc[i].size(), 0);
         check($sformatf("stray[%0d] busy", i), busy[i], 0);
         check($sformatf("stray[%0d] ready", i), req_ready[i], 1);
      end

      // directed requests
      r = '{conn_id: 32'd5, open: 1'b1, dest_ip: 32'h0A000002, dest_port: 16'h1F90, client_flow_id: 16'd3};
      run_txn("open_ok", r, 0, 10);
      r = '{conn_id: 32'd5, open: 1'b0, dest_ip: 32'h0, dest_port: 16'h0, client_flow_id: 16'h0};
      run_txn("close_err", r, 1, 3);
      r = '{conn_id: 32'h77, open: 1'b1, dest_ip: 32'hC0A80101, dest_port: 16'h0050, client_flow_id: 16'h1234};
      run_txn("timeout", r, 2, 1);
      r.conn_id = 32'h1001;
      run_txn("st_at_expiry", r, 0, TO - 1);
      r.conn_id = 32'h1002;
      run_txn("st_after_expiry", r, 1, TO);

      // reset during the DEST_PORT frame
      clear_mon();
      rs_kind = 0;
      rs_dly = 5;
      r = '{conn_id: 32'hBEEF, open: 1'b1, dest_ip: 32'h01020304, dest_port: 16'h0A0B, client_flow_id: 16'h9};
      @(posedge clk); #1;
      req_in = r;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk); #1;
         if (fq[0].size() >= 4) break;
      end
      check("midreset nframes", fq[0].size(), 4);
      if (fq[0].size() != 0)
         check("midreset last_cmd", fq[0][fq[0].size() - 1].cmd, setUpDestPort);
      reset = 1'b1;
      @(negedge clk);
      check_outputs_reset("midreset");
      #1;
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
         check($sformatf("midreset[%0d] ndone", i), dq_cyc[i].size(), 0);
      check("midreset no_more_frames", fq[0].size(), 4);
      run_txn("after_reset", r, 0, 4);

      // random requests
      for (int k = 0; k < 8; k++) begin
         r.conn_id = $urandom;
         r.open = 1'($urandom_range(0, 1));
         r.dest_ip = $urandom;
         r.dest_port = 16'($urandom);
         r.client_flow_id = 16'($urandom);
         run_txn($sformatf("rnd%0d", k), r, int'($urandom_range(0, 2)), int'($urandom_range(1, TO + 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
